mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised synchronous modulo-N up/down counter. It is the next generation after the single JK flip-flop and ripple counter stages.
- Replaces chains of toggling flip-flops with one registered count that adds:
  - a programmable modulus;
  - up, down, hold and load modes;
  - a clock-enable prescaler;
  - a cascadable terminal-count output.
- Intended as the standard counter primitive for the counters library.
- Instances cascade by wiring tc of one stage to enable of the next.

Parameters:
- WIDTH, 4: count register width in bits.
- MODULUS, 10: count range is 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.
- PRESCALE, 1: number of enabled cycles per count step. Must be >= 1; 1 means a step on every enabled cycle.

Ports:
- clk, input, 1: rising-edge clock, single clock domain.
- clr, input, 1: asynchronous, active-low reset.
- enable, input, 1: count/prescale enable; also the cascade input.
- mode, input, 2: 00 hold, 01 count down, 10 count up, 11 load.
- din, input, WIDTH: parallel load value, sampled when mode=11.
- q, output, WIDTH: current count, registered.
- qbar, output, WIDTH: bitwise complement of q, always ~q.
- tc, output, 1: combinational terminal count, for cascading.
- wrap, output, 1: registered one-cycle pulse, asserted the cycle after a wrap-around.

Behaviour:
- Reset, clr=0, asynchronous, independent of clk:
  - q=0, qbar=all ones, wrap=0, prescaler count=0.
  - tc follows its equation from the reset value of q.
  - Deasserting clr mid-operation resumes from q=0; no partial step is retained.
- Prescaler: internal counter ps runs 0..PRESCALE-1.
  - Increments on each rising edge where enable=1 and mode is 01 or 10.
  - Wraps from PRESCALE-1 to 0.
  - A step is taken when ps==PRESCALE-1, or always when PRESCALE=1.
  - ps holds when enable=0 or mode=00.
  - ps clears to 0 when mode=11.
- Step condition: step = enable & (mode==01 | mode==10) & (ps==PRESCALE-1).
- Count up, mode=10 and step: q <= (q==MODULUS-1) ? 0 : q+1.
- Count down, mode=01 and step: q <= (q==0) ? MODULUS-1 : q-1.
- Hold, mode=00, or enable=0 with mode 01/10: q unchanged.
- Load, mode=11: acts on every rising edge and ignores enable.
  - q <= din if din <= MODULUS-1; otherwise q <= MODULUS-1 (saturate).
  - No wrap pulse.
- tc, combinational:
  - tc = step & ((mode==10 & q==MODULUS-1) | (mode==01 & q==0)).
  - High only in the cycle whose next edge wraps q.
- wrap: wrap <= tc on each edge, so it is high exactly one cycle after the wrap edge.
- Out-of-range q (q >= MODULUS) can occur only if MODULUS < 2**WIDTH and via no legal path. If it is forced, count up returns to 0 on the next step and count down decrements normally.
- No X propagation: a mode or din containing X must not be reachable after reset in the bench.
- Latency: q changes 1 clock after the step or load edge; tc has zero latency relative to q, mode and enable.

Decomposition:
- Shared package counter_pkg:
  - mode encodings MODE_HOLD=2'b00, MODE_DOWN=2'b01, MODE_UP=2'b10, MODE_LOAD=2'b11;
  - a parameter-legality check function.
- One natural sub-module: clk_prescaler.
  - Parameter PRESCALE.
  - Ports clk, clr, enable (= enable & counting mode), sync_clear (= load), tick (= step term).
- Top level holds the count register, next-state mux, tc and wrap logic.

Test Plan:
- Reset: clr=0 mid-count at q=7 -> q=0, qbar=4'hF, wrap=0 immediately, without a clock edge. Release clr -> next up step gives q=1.
- Up wrap, WIDTH=4, MODULUS=10, PRESCALE=1, mode=10, enable=1 from q=0:
  - q goes 0..9, then 0;
  - tc=1 only while q=9;
  - wrap=1 for one cycle when q=0 after the wrap.
- Down wrap, mode=01 from q=0: q goes 0, 9, 8, ...; tc=1 only while q=0; wrap pulses once.
- Load and saturate:
  - mode=11, din=5, enable=0 -> q=5 on the next edge.
  - din=13 -> q=9.
  - Neither case raises tc or wrap.
- Prescale, PRESCALE=3, mode=10, enable=1: q increments every 3rd edge.
  - Drop enable for 2 cycles mid-period -> ps and q hold, and the period resumes where it stopped.
  - tc is high only on the final prescale cycle with q=9.
- Cascade: two instances with MODULUS=10; stage0.tc drives stage1.enable; both mode=10.
  - After 100 edges from reset the pair reads 00 again.
  - stage1.wrap pulses exactly once, the cycle after edge 100.

Source files
------------

// File: rtl/counter_pkg.sv
// ============================================================================
// counter_pkg : mode encodings and parameter legality check for counters
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_UP   = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  function automatic bit params_legal(input int width, input int modulus,
                                      input int prescale);
    if (width < 1 || width > 62) return 1'b0;
    if (modulus < 2) return 1'b0;
    if (longint'(modulus) > (longint'(1) << width)) return 1'b0;
    return (prescale >= 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_prescaler.sv
// ============================================================================
// clk_prescaler : enable-gated divide-by-PRESCALE step generator
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic enable,
  input  logic sync_clear,
  output logic tick
);

  // A 1-bit counter pinned at zero covers PRESCALE=1 with the same datapath.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ps <= '0;
    end else if (sync_clear) begin
      ps <= '0;
    end else if (enable) begin
      ps <= (ps == PS_LAST) ? '0 : ps + 1'b1;
    end
  end

  assign tick = enable & (ps == PS_LAST);

endmodule

`default_nettype wire

// File: rtl/mod_updown_counter.sv
// ============================================================================
// mod_updown_counter : modulo-N up/down/hold/load counter, cascadable tc
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  generate
    if (!params_legal(WIDTH, MODULUS, PRESCALE)) begin : g_param_check
      $error("mod_updown_counter: illegal WIDTH/MODULUS/PRESCALE combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

  logic             counting;
  logic             loading;
  logic             ps_enable;
  logic             step;
  logic [WIDTH-1:0] q_next;

  assign counting  = (mode == MODE_UP) || (mode == MODE_DOWN);
  assign loading   = (mode == MODE_LOAD);
  assign ps_enable = enable & counting;

  clk_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk        (clk),
    .clr        (clr),
    .enable     (ps_enable),
    .sync_clear (loading),
    .tick       (step)
  );

  // Up-count uses >= so a forced out-of-range value recovers to 0.
  always_comb begin
    q_next = q;
    case (mode)
      MODE_UP:   if (step) q_next = (q >= Q_MAX) ? '0 : q + 1'b1;
      MODE_DOWN: if (step) q_next = (q == '0) ? Q_MAX : q - 1'b1;
      MODE_LOAD: q_next = (din > Q_MAX) ? Q_MAX : din;
      default:   q_next = q;
    endcase
  end

  assign tc   = step & (((mode == MODE_UP) && (q == Q_MAX)) ||
                        ((mode == MODE_DOWN) && (q == '0)));
  assign qbar = ~q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= tc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// ============================================================================
// tb_mod_updown_counter : scoreboard bench for mod_updown_counter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mod_updown_counter;
  import counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut 0: PRESCALE=1, dut 1: PRESCALE=3, dut 2: two-stage decade cascade
  logic       clr_a, en0, tc0, wrap0;
  logic [1:0] mode0;
  logic [3:0] din0, q0, qb0;
  logic       clr_b, en1, tc1, wrap1;
  logic [1:0] mode1;
  logic [3:0] din1, q1, qb1;
  logic       clr_c, en_c, lo_tc, lo_wrap, hi_tc, hi_wrap;
  logic [1:0] mode_c;
  logic [3:0] din_c, lo_q, lo_qb, hi_q, hi_qb;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_dut0 (
    .clk(clk), .clr(clr_a), .enable(en0), .mode(mode0), .din(din0),
    .q(q0), .qbar(qb0), .tc(tc0), .wrap(wrap0));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_dut1 (
    .clk(clk), .clr(clr_b), .enable(en1), .mode(mode1), .din(din1),
    .q(q1), .qbar(qb1), .tc(tc1), .wrap(wrap1));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_stage0 (
    .clk(clk), .clr(clr_c), .enable(en_c), .mode(mode_c), .din(din_c),
    .q(lo_q), .qbar(lo_qb), .tc(lo_tc), .wrap(lo_wrap));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_stage1 (
    .clk(clk), .clr(clr_c), .enable(lo_tc), .mode(mode_c), .din(din_c),
    .q(hi_q), .qbar(hi_qb), .tc(hi_tc), .wrap(hi_wrap));

  typedef struct {
    int         dut;
    logic [7:0] q;
    logic [1:0] tc;
    logic [1:0] wrap;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic expect_vec(input int dut, input int qv, input logic [1:0] t,
                            input logic [1:0] w, input string nm);
    exp_t e;
    e.dut  = dut;
    e.q    = 8'(qv);
    e.tc   = t;
    e.wrap = w;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are stable mid-cycle, so every queued vector is judged
  // on the falling edge following its issue.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] aq, aqb, eqb;
      logic [1:0] at, aw;
      e = sb.pop_front();
      case (e.dut)
        0: begin
          aq = {4'h0, q0}; aqb = {4'hF, qb0}; at = {1'b0, tc0}; aw = {1'b0, wrap0};
        end
        1: begin
          aq = {4'h0, q1}; aqb = {4'hF, qb1}; at = {1'b0, tc1}; aw = {1'b0, wrap1};
        end
        default: begin
          aq = {hi_q, lo_q}; aqb = {hi_qb, lo_qb};
          at = {lo_tc, hi_tc}; aw = {lo_wrap, hi_wrap};
        end
      endcase
      eqb = ~e.q;
      n_vec++;
      if (aq !== e.q || aqb !== eqb || at !== e.tc || aw !== e.wrap) begin
        n_miss++;
        $display("FAIL %s: got q=%h qbar=%h tc=%b wrap=%b, want q=%h qbar=%h tc=%b wrap=%b",
                 e.name, aq, aqb, at, aw, e.q, eqb, e.tc, e.wrap);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    clr_a = 1'b0; en0 = 1'b0; mode0 = MODE_HOLD; din0 = 4'h0;
    clr_b = 1'b0; en1 = 1'b0; mode1 = MODE_HOLD; din1 = 4'h0;
    clr_c = 1'b0; en_c = 1'b0; mode_c = MODE_HOLD; din_c = 4'h0;
    tick();
    tick();
    expect_vec(0, 0, 2'b00, 2'b00, "rst_dut0");
    expect_vec(1, 0, 2'b00, 2'b00, "rst_dut1");
    expect_vec(2, 0, 2'b00, 2'b00, "rst_cascade");
    tick();

    // ---------------- dut0: reset, up/down wrap, load, hold ----------------
    clr_a = 1'b1; clr_b = 1'b1;
    mode0 = MODE_LOAD; din0 = 4'd7;
    expect_vec(0, 0, 2'b00, 2'b00, "a_release_load7");
    tick();
    // q is 7 here; reset is applied between clock edges
    mode0 = MODE_UP; en0 = 1'b1; clr_a = 1'b0;
    expect_vec(0, 0, 2'b00, 2'b00, "a_async_clr_at_7");
    tick();
    clr_a = 1'b1;
    expect_vec(0, 0, 2'b00, 2'b00, "a_clr_release");
    tick();
    mode0 = MODE_LOAD; din0 = 4'd0;
    expect_vec(0, 1, 2'b00, 2'b00, "a_first_up_step");
    tick();

    mode0 = MODE_UP;
    for (int k = 0; k < 12; k++) begin
      expect_vec(0, k % 10, {1'b0, (k % 10) == 9}, {1'b0, k == 10}, "a_up_wrap");
      tick();
    end

    mode0 = MODE_LOAD; din0 = 4'd0;
    expect_vec(0, 2, 2'b00, 2'b00, "a_load0");
    tick();
    mode0 = MODE_DOWN;
    for (int k = 0; k < 11; k++) begin
      int qk;
      qk = (10 - (k % 10)) % 10;
      expect_vec(0, qk, {1'b0, qk == 0}, {1'b0, k == 1}, "a_down_wrap");
      tick();
    end

    mode0 = MODE_LOAD; din0 = 4'd5; en0 = 1'b0;
    expect_vec(0, 9, 2'b00, 2'b01, "a_load5_pre");
    tick();
    din0 = 4'd13;
    expect_vec(0, 5, 2'b00, 2'b00, "a_load5");
    tick();
    mode0 = MODE_UP;
    expect_vec(0, 9, 2'b00, 2'b00, "a_load13_saturate");
    tick();
    expect_vec(0, 9, 2'b00, 2'b00, "a_up_disabled");
    tick();
    mode0 = MODE_HOLD; en0 = 1'b1;
    expect_vec(0, 9, 2'b00, 2'b00, "a_hold");
    tick();
    mode0 = MODE_UP;
    expect_vec(0, 9, 2'b01, 2'b00, "a_tc_at_max");
    tick();
    mode0 = MODE_HOLD;
    expect_vec(0, 0, 2'b00, 2'b01, "a_wrap_pulse");
    tick();
    expect_vec(0, 0, 2'b00, 2'b00, "a_wrap_clear");
    tick();

    // ---------------- dut1: prescale by 3 with enable gap ----------------
    mode1 = MODE_UP; en1 = 1'b1;
    expect_vec(1, 0, 2'b00, 2'b00, "b_ps0");
    tick();
    en1 = 1'b0;
    expect_vec(1, 0, 2'b00, 2'b00, "b_gap1");
    tick();
    expect_vec(1, 0, 2'b00, 2'b00, "b_gap2");
    tick();
    en1 = 1'b1;
    expect_vec(1, 0, 2'b00, 2'b00, "b_resume_ps1");
    tick();
    expect_vec(1, 0, 2'b00, 2'b00, "b_ps2");
    tick();
    expect_vec(1, 1, 2'b00, 2'b00, "b_step");
    tick();
    mode1 = MODE_LOAD; din1 = 4'd9;
    expect_vec(1, 1, 2'b00, 2'b00, "b_load9_pre");
    tick();
    mode1 = MODE_UP;
    expect_vec(1, 9, 2'b00, 2'b00, "b_q9_ps0");
    tick();
    expect_vec(1, 9, 2'b00, 2'b00, "b_q9_ps1");
    tick();
    expect_vec(1, 9, 2'b01, 2'b00, "b_tc_final_ps");
    tick();
    mode1 = MODE_HOLD;
    expect_vec(1, 0, 2'b00, 2'b01, "b_wrap_pulse");
    tick();
    expect_vec(1, 0, 2'b00, 2'b00, "b_after_wrap");
    tick();

    // ---------------- cascade: 00..99 and back to 00 ----------------
    clr_c = 1'b1; mode_c = MODE_UP; en_c = 1'b1;
    for (int n = 0; n < 102; n++) begin
      int m;
      m = n % 100;
      expect_vec(2, ((m / 10) * 16) + (m % 10),
                 {(n % 10) == 9, n == 99},
                 {(n > 0) && ((n % 10) == 0), n == 100},
                 "c_cascade");
      tick();
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d vectors still queued, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
